mux4x1_lanes: RTL and testbench

- Bit-sliced 4:1 selector used as the ALU's basic primitive.
- Serves as the per-bit Boolean truth-table lookup: data = 4-bit function code, select = {A[i], B[i]}.
- Serves as the per-bit result selector between the CMP, ARITH, BOOL and SHIFT units, with select = FN[5:4].
- Provides a combinational output plus a registered copy for pipelined use.

---
 rtl/mux4x1_lanes_if.sv | 21 ++
 rtl/mux4x1_lanes.sv | 70 +++++++
 tb/tb_mux4x1_lanes.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/mux4x1_lanes_if.sv
// Bus bundle for mux4x1_lanes: per-lane data nibbles, selects and results.
// The y_par signal exists only when MUX4X1_PARITY_EN is defined.
interface mux4x1_lanes_if #(
    parameter int LANES = 1
) ();
    logic                 en;
    logic [4*LANES-1:0]   d;
    logic [2*LANES-1:0]   sel;
    logic [LANES-1:0]     y;
    logic [LANES-1:0]     y_q;
    logic                 y_vld;
`ifdef MUX4X1_PARITY_EN
    logic                 y_par;

    modport master (output en, d, sel, input y, y_q, y_vld, y_par);
    modport slave  (input en, d, sel, output y, y_q, y_vld, y_par);
`else
    modport master (output en, d, sel, input y, y_q, y_vld);
    modport slave  (input en, d, sel, output y, y_q, y_vld);
`endif
endinterface

// File: rtl/mux4x1_lanes.sv
// Bit-sliced 4:1 selector with combinational and registered outputs.
// Optional registered parity of the result when MUX4X1_PARITY_EN is defined.
module mux4x1_lanes #(
    parameter int LANES = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    mux4x1_lanes_if.slave  bus
);

    logic [LANES-1:0] w_y;
    logic [LANES-1:0] r_y_q;
    logic             r_y_vld;

`ifdef MUX4X1_PARITY_EN
    logic             r_y_par;

    function automatic logic f_parity(input logic [LANES-1:0] v);
        return ^v;
    endfunction
`endif

    // Per-lane nibble lookup; an unknown select propagates X to that lane only
    always_comb begin
        w_y = {LANES{1'b0}};
        for (int i = 0; i < LANES; i++) begin
            case (bus.sel[2*i +: 2])
                2'b00:   w_y[i] = bus.d[4*i];
                2'b01:   w_y[i] = bus.d[4*i + 1];
                2'b10:   w_y[i] = bus.d[4*i + 2];
                2'b11:   w_y[i] = bus.d[4*i + 3];
                default: w_y[i] = 1'bx;
            endcase
        end
    end

    // Capture register: result held while en is low, valid pulses after a capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y_q   <= {LANES{1'b0}};
            r_y_vld <= 1'b0;
        end else if (bus.en) begin
            r_y_q   <= w_y;
            r_y_vld <= 1'b1;
        end else begin
            r_y_q   <= r_y_q;
            r_y_vld <= 1'b0;
        end
    end

`ifdef MUX4X1_PARITY_EN
    // Parity register tracks r_y_q so both always describe the same capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y_par <= 1'b0;
        end else if (bus.en) begin
            r_y_par <= f_parity(w_y);
        end else begin
            r_y_par <= r_y_par;
        end
    end

    assign bus.y_par = r_y_par;
`endif

    assign bus.y     = w_y;
    assign bus.y_q   = r_y_q;
    assign bus.y_vld = r_y_vld;

endmodule

// File: tb/tb_mux4x1_lanes.sv
// Self-checking bench for mux4x1_lanes: one 1-lane and one 32-lane instance,
// directed ALU/Boolean cases plus randomized traffic against a reference model.
module tb_mux4x1_lanes;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mux4x1_lanes_if #(.LANES(1))  bus1 ();
    mux4x1_lanes_if #(.LANES(32)) bus32 ();

    mux4x1_lanes #(.LANES(1))  dut1  (.clk(clk), .rst_n(rst_n), .bus(bus1));
    mux4x1_lanes #(.LANES(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));

    int n_chk  = 0;
    int n_pass = 0;

    logic        exp_q1;
    logic [31:0] exp_q32;
    logic        exp_vld;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    // Lane i output is bit number (4*i + select_i) of the flattened data word
    function automatic logic [63:0] ref_mux(input logic [127:0] d, input logic [63:0] sel, input int lanes);
        logic [63:0] r;
        int s;
        r = 64'd0;
        for (int i = 0; i < lanes; i++) begin
            s = int'((sel >> (2*i)) & 64'd3);
            r[i] = d[4*i + s];
        end
        return r;
    endfunction

    function automatic logic [127:0] build_d32(input logic [31:0] cmp, input logic [31:0] arith,
                                               input logic [31:0] bool_v, input logic [31:0] shift);
        logic [127:0] r;
        for (int i = 0; i < 32; i++) begin
            r[4*i +: 4] = {shift[i], bool_v[i], arith[i], cmp[i]};
        end
        return r;
    endfunction

    task automatic apply(input logic en, input logic [3:0] d1, input logic [1:0] s1,
                         input logic [127:0] d32, input logic [63:0] s32);
        bus1.en   = en;  bus1.d  = d1;  bus1.sel  = s1;
        bus32.en  = en;  bus32.d = d32; bus32.sel = s32;
        #1;
        check_val("y1_model",  {63'd0, bus1.y}, ref_mux({124'd0, d1}, {62'd0, s1}, 1));
        check_val("y32_model", {32'd0, bus32.y}, ref_mux(d32, s32, 32));
    endtask

    task automatic check_regs(input string tag);
        check_val({tag, "_q1"},    {63'd0, bus1.y_q},   {63'd0, exp_q1});
        check_val({tag, "_q32"},   {32'd0, bus32.y_q},  {32'd0, exp_q32});
        check_val({tag, "_vld1"},  {63'd0, bus1.y_vld}, {63'd0, exp_vld});
        check_val({tag, "_vld32"}, {63'd0, bus32.y_vld}, {63'd0, exp_vld});
`ifdef MUX4X1_PARITY_EN
        check_val({tag, "_par1"},  {63'd0, bus1.y_par},  {63'd0, exp_q1});
        check_val({tag, "_par32"}, {63'd0, bus32.y_par}, {63'd0, ^exp_q32});
`endif
    endtask

    // Advance one clock; the model captures what the bench drove before the edge
    task automatic tick(input string tag);
        logic [63:0] r1;
        logic [63:0] r32;
        r1  = ref_mux({124'd0, bus1.d}, {62'd0, bus1.sel}, 1);
        r32 = ref_mux(bus32.d, {bus32.sel}, 32);
        @(posedge clk);
        if (bus1.en) begin
            exp_q1  = r1[0];
            exp_q32 = r32[31:0];
        end
        exp_vld = bus1.en;
        #1;
        check_regs(tag);
    endtask

    logic [3:0]   and_fn;
    logic [3:0]   or_fn;
    logic [3:0]   and_exp;
    logic [3:0]   or_exp;
    logic [127:0] alu_d;

    initial begin
        rst_n = 1'b0;
        bus1.en = 1'b0;  bus1.d = 4'd0;    bus1.sel = 2'd0;
        bus32.en = 1'b0; bus32.d = 128'd0; bus32.sel = 64'd0;
        exp_q1 = 1'b0; exp_q32 = 32'd0; exp_vld = 1'b0;
        #12;
        check_regs("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_regs("post_rst");

        and_fn = 4'b1000; or_fn = 4'b1110;
        and_exp = 4'b1000; or_exp = 4'b1110;
        alu_d = build_d32(32'h1, 32'h5, 32'h5, 32'h1);
        for (int s = 0; s < 4; s++) begin
            apply(1'b1, and_fn, 2'(s), alu_d, {32{2'(s)}});
            check_val("and_y", {63'd0, bus1.y}, {63'd0, and_exp[s]});
            check_val("alu_y", {32'd0, bus32.y}, (s == 1 || s == 2) ? 64'h5 : 64'h1);
            tick("and");
        end
        for (int s = 0; s < 4; s++) begin
            apply(1'b1, or_fn, 2'(s), alu_d, {32{2'(s)}});
            check_val("or_y", {63'd0, bus1.y}, {63'd0, or_exp[s]});
            tick("or");
        end

        // hold: capture a 1, then drop en and change data
        apply(1'b1, 4'b1000, 2'b11, alu_d, {32{2'b01}});
        tick("hold_cap");
        check_val("hold_cap_q", {63'd0, bus1.y_q}, 64'd1);
        apply(1'b0, 4'b0000, 2'b11, alu_d, {32{2'b00}});
        check_val("hold_y", {63'd0, bus1.y}, 64'd0);
        tick("hold");
        check_val("hold_q", {63'd0, bus1.y_q}, 64'd1);
        check_val("hold_vld", {63'd0, bus1.y_vld}, 64'd0);

        // reset between edges clears registers immediately
        apply(1'b1, 4'b1000, 2'b11, alu_d, {32{2'b01}});
        tick("pre_rst");
        #2;
        rst_n = 1'b0;
        bus1.en = 1'b0; bus32.en = 1'b0;
        #1;
        exp_q1 = 1'b0; exp_q32 = 32'd0; exp_vld = 1'b0;
        check_regs("midrst");
        check_val("midrst_vld_now", {63'd0, bus1.y_vld}, 64'd0);
        bus1.d = 4'b0001; bus1.sel = 2'b00;
        #1;
        check_val("midrst_y_follows", {63'd0, bus1.y}, 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_regs("rst_rel");

        for (int n = 0; n < 300; n++) begin
            apply(1'($urandom_range(0, 1)), 4'($urandom), 2'($urandom),
                  {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom});
            tick("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
